// File: rtl/linebuf_scanout_if.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_scanout_if
//  Description : Scanout-side bundle: line-buffer read port, renderer line
//                handshake, pixel-step control and video outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface linebuf_scanout_if;
  logic       pix_ce;
  logic       vactive;
  logic [8:0] idx2;
  logic [5:0] rddata2;
  logic       linesel;
  logic       line_start;
  logic [5:0] pixel;
  logic       pixel_de;
  logic       hsync;

  modport master (
    input  pix_ce, vactive, rddata2,
    output idx2, linesel, line_start, pixel, pixel_de, hsync
  );

  modport slave (
    output pix_ce, vactive, rddata2,
    input  idx2, linesel, line_start, pixel, pixel_de, hsync
  );
endinterface
`default_nettype wire

// File: rtl/linebuf_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_scanout
//  Description : Horizontal timing and double-buffered line scanout with a
//                one-pixel-step registered output stage.
//                Optional macro LINEBUF_SCANOUT_BORDER_EN adds border_color
//                as the blanking value.
//  Revision    : 1.0 - initial release
// ============================================================================
module linebuf_scanout #(
  parameter int H_ACTIVE = 320,
  parameter int H_FPORCH = 16,
  parameter int H_SYNC   = 48,
  parameter int H_TOTAL  = 424
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
`ifdef LINEBUF_SCANOUT_BORDER_EN
  input  wire logic [5:0]     border_color,
`endif
  linebuf_scanout_if.master   bus
);

  // Region bounds held at 10 bits so H_TOTAL = 512 cannot overflow a compare.
  localparam logic [9:0] c_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] c_SYNC_BEG = 10'(H_ACTIVE + H_FPORCH);
  localparam logic [9:0] c_SYNC_END = 10'(H_ACTIVE + H_FPORCH + H_SYNC);
  localparam logic [8:0] c_LAST     = 9'(H_TOTAL - 1);

  logic [8:0] hcnt_q, hcnt_d;
  logic       linesel_q, linesel_d;
  logic       line_shown_q, line_shown_d;
  logic       line_start_q, line_start_d;
  logic [5:0] pixel_q, pixel_d;
  logic       pixel_de_q, pixel_de_d;
  logic       hsync_q, hsync_d;

  logic       w_active;
  logic       w_sync;
  logic       w_wrap;
  logic       w_show;
  logic [5:0] w_blank;

  assign w_active = {1'b0, hcnt_q} < c_ACT_END;
  assign w_sync   = ({1'b0, hcnt_q} >= c_SYNC_BEG) && ({1'b0, hcnt_q} < c_SYNC_END);
  assign w_wrap   = hcnt_q == c_LAST;
  assign w_show   = w_active && line_shown_q;

`ifdef LINEBUF_SCANOUT_BORDER_EN
  assign w_blank = border_color;
`else
  assign w_blank = 6'h00;
`endif

  always_comb begin
    hcnt_d       = hcnt_q;
    linesel_d    = linesel_q;
    line_shown_d = line_shown_q;
    line_start_d = 1'b0;
    pixel_d      = pixel_q;
    pixel_de_d   = pixel_de_q;
    hsync_d      = hsync_q;
    if (bus.pix_ce) begin
      if (w_wrap) begin
        hcnt_d       = 9'd0;
        linesel_d    = ~linesel_q;
        line_shown_d = bus.vactive;
        line_start_d = 1'b1;
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
      // Output reflects the pre-edge hcnt; rddata2 has had one idle clk to settle.
      pixel_d    = w_show ? bus.rddata2 : w_blank;
      pixel_de_d = w_show;
      hsync_d    = w_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt_q       <= 9'd0;
      linesel_q    <= 1'b0;
      line_shown_q <= 1'b0;
      line_start_q <= 1'b0;
      pixel_q      <= 6'h00;
      pixel_de_q   <= 1'b0;
      hsync_q      <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      linesel_q    <= linesel_d;
      line_shown_q <= line_shown_d;
      line_start_q <= line_start_d;
      pixel_q      <= pixel_d;
      pixel_de_q   <= pixel_de_d;
      hsync_q      <= hsync_d;
    end
  end

  assign bus.idx2       = w_active ? hcnt_q : 9'd0;
  assign bus.linesel    = linesel_q;
  assign bus.line_start = line_start_q;
  assign bus.pixel      = pixel_q;
  assign bus.pixel_de   = pixel_de_q;
  assign bus.hsync      = hsync_q;

endmodule
`default_nettype wire

// File: tb/tb_linebuf_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_linebuf_scanout
//  Description : Self-checking bench for linebuf_scanout (scoreboard plus
//                table of line checkpoints).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_linebuf_scanout;

`ifdef LINEBUF_SCANOUT_BORDER_EN
  localparam logic [5:0] c_BLANK = 6'h2A;
`else
  localparam logic [5:0] c_BLANK = 6'h00;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] border_color = 6'h2A;

  linebuf_scanout_if bus();

  linebuf_scanout #(
    .H_ACTIVE (320),
    .H_FPORCH (16),
    .H_SYNC   (48),
    .H_TOTAL  (424)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef LINEBUF_SCANOUT_BORDER_EN
    .border_color (border_color),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Line-buffer RAM model: one-clock read latency, contents = index.
  always_ff @(posedge clk) bus.rddata2 <= bus.idx2[5:0];

  typedef struct {
    logic [5:0] pix;
    logic       de;
    logic       hs;
    logic       ls;
    logic       sel;
  } exp_t;

  typedef struct {
    int         hc;
    logic [5:0] pix;
    logic       de;
    logic       hs;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[12];

  int n_cmp = 0;
  int n_bad = 0;
  int m_hcnt = 0;
  logic m_sel = 1'b0;
  logic m_shown = 1'b0;
  int step_no = 0;
  int hs_cnt = 0;
  int hs_first = 0;
  int ls_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel step: pix_ce for one clk, then one idle clk.
  task automatic pstep();
    exp_t e;
    logic wrap;
    wrap  = (m_hcnt == 423);
    e.de  = (m_hcnt < 320) && m_shown;
    e.pix = e.de ? 6'(m_hcnt) : c_BLANK;
    e.hs  = (m_hcnt >= 336) && (m_hcnt < 384);
    e.ls  = wrap;
    e.sel = m_sel ^ wrap;
    sb_q.push_back(e);

    bus.pix_ce = 1'b1;
    @(posedge clk); #1;
    bus.pix_ce = 1'b0;
    if (wrap) begin
      m_hcnt  = 0;
      m_sel   = ~m_sel;
      m_shown = bus.vactive;
    end else begin
      m_hcnt++;
    end

    step_no++;
    if (bus.hsync) begin
      hs_cnt++;
      if (hs_first == 0) hs_first = step_no;
    end
    if (bus.line_start) ls_cnt++;

    e = sb_q.pop_front();
    chk("pixel", bus.pixel, e.pix);
    chk("pixel_de", bus.pixel_de, e.de);
    chk("hsync", bus.hsync, e.hs);
    chk("line_start", bus.line_start, e.ls);
    chk("linesel", bus.linesel, e.sel);
    chk("idx2", bus.idx2, (m_hcnt < 320) ? m_hcnt : 0);

    @(posedge clk); #1;
    chk("line_start_fall", bus.line_start, 0);
    chk("pixel_hold", bus.pixel, e.pix);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) pstep();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int cnt;

    tbl[0]  = '{0,   6'd0,    1'b1, 1'b0};
    tbl[1]  = '{1,   6'd1,    1'b1, 1'b0};
    tbl[2]  = '{63,  6'd63,   1'b1, 1'b0};
    tbl[3]  = '{64,  6'd0,    1'b1, 1'b0};
    tbl[4]  = '{200, 6'd8,    1'b1, 1'b0};
    tbl[5]  = '{319, 6'd63,   1'b1, 1'b0};
    tbl[6]  = '{320, c_BLANK, 1'b0, 1'b0};
    tbl[7]  = '{335, c_BLANK, 1'b0, 1'b0};
    tbl[8]  = '{336, c_BLANK, 1'b0, 1'b1};
    tbl[9]  = '{383, c_BLANK, 1'b0, 1'b1};
    tbl[10] = '{384, c_BLANK, 1'b0, 1'b0};
    tbl[11] = '{423, c_BLANK, 1'b0, 1'b0};

    // Reset with pix_ce toggling; it must be ignored.
    bus.pix_ce  = 1'b0;
    bus.vactive = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.pix_ce = i[0];
      @(posedge clk); #1;
    end
    bus.pix_ce = 1'b0;
    chk("rst_pixel", bus.pixel, 0);
    chk("rst_de", bus.pixel_de, 0);
    chk("rst_hsync", bus.hsync, 0);
    chk("rst_line_start", bus.line_start, 0);
    chk("rst_linesel", bus.linesel, 0);
    chk("rst_idx2", bus.idx2, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Line 0: not shown (line_shown cleared by reset), wraps after 424 steps.
    steps(424);
    chk("line0_ls_count", ls_cnt, 1);
    chk("line0_linesel", bus.linesel, 1);
    chk("hsync_count", hs_cnt, 48);
    chk("hsync_first_step", hs_first, 337);

    // Line 1: shown; checkpoints from the table. vactive=0 for the next wrap.
    bus.vactive = 1'b0;
    foreach (tbl[k]) begin
      guard = 0;
      while (m_hcnt != tbl[k].hc && guard < 500) begin
        pstep();
        guard++;
      end
      chk("tbl_reach", m_hcnt, tbl[k].hc);
      pstep();
      chk($sformatf("tbl%0d_pixel", k), bus.pixel, tbl[k].pix);
      chk($sformatf("tbl%0d_de", k), bus.pixel_de, tbl[k].de);
      chk($sformatf("tbl%0d_hsync", k), bus.hsync, tbl[k].hs);
    end
    chk("line1_linesel", bus.linesel, 0);

    // Line 2: vactive was 0 at wrap, so blank throughout; next line shown.
    bus.vactive = 1'b1;
    steps(424);
    chk("line2_linesel", bus.linesel, 1);

    // Line 3: reset mid-line at hcnt=200, pix_ce held high during reset.
    steps(200);
    reset_n = 1'b0;
    bus.pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.pix_ce = 1'b0;
    chk("mid_rst_pixel", bus.pixel, 0);
    chk("mid_rst_de", bus.pixel_de, 0);
    chk("mid_rst_hsync", bus.hsync, 0);
    chk("mid_rst_line_start", bus.line_start, 0);
    chk("mid_rst_linesel", bus.linesel, 0);
    chk("mid_rst_idx2", bus.idx2, 0);
    reset_n = 1'b1;
    m_hcnt  = 0;
    m_sel   = 1'b0;
    m_shown = 1'b0;
    @(posedge clk); #1;

    cnt = 0;
    ls_cnt = 0;
    while (ls_cnt == 0 && cnt < 500) begin
      pstep();
      cnt++;
    end
    chk("post_rst_wrap_steps", cnt, 424);
    chk("post_rst_linesel", bus.linesel, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/linebuf_scanout.md
LINEBUF_SCANOUT -- requirements
Module: linebuf_scanout

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 320, giving the active pixels per line.
REQ-002 The block SHALL have parameter H_FPORCH, default 16, giving the front-porch length in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 48, giving the hsync pulse length in pixels.
REQ-004 The block SHALL have parameter H_TOTAL, default 424, giving the total pixels per line; the back porch is the remainder; H_TOTAL SHALL be at most 512.
REQ-005 The block SHALL have the following ports.
- clk  in  1  the only clock.
- reset_n  in  1  synchronous, active-low reset.
- pix_ce  in  1  pixel-step enable; hcnt advances only on clk edges where pix_ce=1.
- vactive  in  1  the current line is displayed; sampled at line wrap.
- idx2  out  9  line-buffer read index, driven to the display-side read port.
- rddata2  in  6  line-buffer read data; the RAM has 1 clk read latency.
- linesel  out  1  line-buffer half selector; the renderer writes half linesel, and scanout reads half !linesel.
- line_start  out  1  1-clk pulse telling the renderer to begin filling the new half.
- pixel  out  6  pixel output.
- pixel_de  out  1  data enable, asserted for active pixels on displayed lines.
- hsync  out  1  horizontal sync, active-high.

Function
REQ-006 hcnt SHALL be a 9-bit counter that increments on each pix_ce and wraps from H_TOTAL-1 to 0.
REQ-007 Region decode SHALL be as follows.
- ACTIVE: hcnt < H_ACTIVE.
- FPORCH: H_ACTIVE <= hcnt < H_ACTIVE+H_FPORCH.
- SYNC: the next H_SYNC counts after FPORCH.
- BPORCH: hcnt < H_TOTAL after SYNC.
REQ-008 idx2 SHALL equal hcnt in ACTIVE and 0 elsewhere, driven combinationally from the hcnt register.
REQ-009 On the pix_ce edge where hcnt wraps to 0, linesel SHALL toggle and line_start SHALL be 1 for exactly that following clk.
REQ-010 At the same wrap edge, a line_shown flag SHALL be loaded from vactive and held for the whole line.
REQ-011 The output stage SHALL update only on pix_ce edges, and each update SHALL reflect the hcnt value before the edge, giving a latency of one pix_ce step.
- At each update, pixel SHALL take rddata2 if that hcnt was ACTIVE and line_shown=1, and the blank value otherwise.
- pixel_de SHALL be 1 under the same condition.
- hsync SHALL be 1 when that hcnt was in SYNC.
REQ-012 pix_ce SHALL NOT be asserted on two consecutive clks; a violation SHALL NOT corrupt hcnt wrap, but pixel data is then undefined.
REQ-013 When pix_ce=0, all outputs SHALL hold, and line_start SHALL fall to 0.
REQ-014 The blank value SHALL be 6'h00, unless overridden per REQ-018.

Reset
REQ-015 While reset_n=0 at a clk edge, the block SHALL reset as follows.
- hcnt=0 and linesel=0.
- line_start=0, pixel=0, pixel_de=0, hsync=0.
- line_shown=0.
- pix_ce SHALL be ignored.
REQ-016 If reset is asserted mid-line, the next line SHALL restart at hcnt=0 with no line_start pulse until the first wrap.
REQ-017 After reset_n rises, the first pix_ce SHALL move hcnt to 1.

Configuration
REQ-018 With macro LINEBUF_SCANOUT_BORDER_EN defined, the block SHALL add input port border_color [5:0], and the blank value SHALL be border_color sampled at the output-stage update; pixel_de behaviour is unchanged.
REQ-019 With LINEBUF_SCANOUT_BORDER_EN undefined, the border_color port SHALL be absent and the blank value SHALL be 6'h00.

Verification
REQ-020 Reset, then pix_ce every 2nd clk for one full line -> hcnt wraps after 424 steps, linesel goes 0->1, and one line_start pulse occurs.
REQ-021 With vactive=1 and a RAM model returning rddata2=idx2[5:0] -> pixel sequence 0,1,...,63,0,... for 320 steps with pixel_de=1, then pixel=0 and pixel_de=0.
REQ-022 Count hsync-high pix_ce steps -> exactly 48, starting at hcnt=336 (output at step 337).
REQ-023 vactive=0 at the wrap -> pixel_de=0 and pixel=0 for the whole line, while linesel still toggles.
REQ-024 Assert reset_n=0 at hcnt=200 for 3 clks -> all outputs are 0, linesel=0, and the next wrap occurs 424 steps after release.
REQ-025 With LINEBUF_SCANOUT_BORDER_EN defined and border_color=6'h2A -> pixel=6'h2A during FPORCH, SYNC and BPORCH, with pixel_de=0.
